if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues in-order word reads to instruction memory, buffers returned
//  words in a small FIFO and presents {pc, inst} to the IF/ID pipeline register under valid/ready.
//  Handles downstream stall and branch/jump redirect, discarding responses fetched on the wrong path.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of the first fetch after reset
//  FIFO_DEPTH  2              fetch-buffer entries; also the max outstanding requests (power of 2, >=2)
// PORTS
//  clk              in   1   clock, all state updates on posedge
//  rst              in   1   asynchronous, active-low reset (0 = reset)
//  redirect_i       in   1   branch/jump taken in EX; pulse, one cycle
//  redirect_pc_i    in   32  new fetch PC; bits [1:0] ignored, forced to 0
//  id_ready_i       in   1   IF/ID can accept this cycle (0 = stall)
//  mem_req_valid_o  out  1   fetch request valid
//  mem_req_ready_i  in   1   memory accepts the request this cycle
//  mem_req_addr_o   out  32  word-aligned fetch address
//  mem_resp_valid_i in   1   read data valid; responses return in request order, >=1 cycle after accept
//  mem_resp_data_i  in   32  instruction word
//  if_valid_o       out  1   if_pc_o/if_inst_o hold a valid instruction
//  if_pc_o          out  32  PC of the presented instruction
//  if_inst_o        out  32  presented instruction word
// BEHAVIOUR
//  - Reset (rst=0, async): pc=RESET_PC, FIFO empty, outstanding=0, discard=0; all outputs 0,
//    if_inst_o=`ZeroWord. First request asserted in the first cycle after rst rises.
//  - Request: mem_req_valid_o=1 iff (outstanding + fifo_count) < FIFO_DEPTH and !redirect_i;
//    mem_req_addr_o=pc. On accept (valid&ready): pc<=pc+4, outstanding+1. Addr/valid held stable until accepted.
//  - Credit rule guarantees every response has a free FIFO slot; overflow is impossible and asserted in sim.
//  - Response: outstanding-1. If discard>0: discard-1, word dropped. Else push {pc_tag, data};
//    pc_tag comes from a tag queue of accepted addresses (in order).
//  - Output: if_valid_o = !fifo_empty; if_pc_o/if_inst_o = FIFO head (registered, no comb path from mem).
//    Pop on if_valid_o & id_ready_i. Push and pop in same cycle allowed (count unchanged), including when full.
//  - Stall: id_ready_i=0 holds the head stable; fetching continues until credits are exhausted.
//  - Redirect (highest priority, same cycle): pc<=redirect_pc_i&~3; FIFO and tag queue flushed;
//    discard<=outstanding after this cycle's response (a response arriving in the redirect cycle is dropped);
//    no request issued and no pop that cycle (if_valid_o still shows the old head, which IF/ID must ignore).
//    First new-path request issued the cycle after the redirect.
//  - Redirect during discard: discard accumulates (still equals all in-flight requests).
//  - Latency: request accepted in cycle N, response in cycle N+k -> if_valid_o in cycle N+k+1.
//  - Widths: PC arithmetic mod 2^32, wraps 32'hFFFF_FFFC -> 0 silently. Counters $clog2(FIFO_DEPTH+1) bits.
//  - Misaligned redirect targets are silently aligned; no exception raised here.
// STRUCTURE
//  - defines.v: `InstAddrBus, `InstBus, `ZeroWord; add `RstEnable_n 1'b0 for the active-low reset.
//  - Sub-module fetch_fifo (params WIDTH, DEPTH): sync FIFO, push/pop/flush, full/empty/count;
//    instantiated twice: 32-bit tag queue (accepted addrs), 64-bit data queue {pc, inst}.
//  - Top holds pc, outstanding and discard counters, request/pop/redirect logic.
// TESTING
//  1. Reset RESET_PC=0x100, 1-cycle memory, id_ready=1 -> addrs 0x100,0x104,0x108; if_pc_o follows in order,
//     if_valid_o first high 2 cycles after the first accept.
//  2. id_ready=0 for 5 cycles -> head stays 0x100, exactly FIFO_DEPTH requests outstanding/buffered, then no
//     requests; release -> 0x100,0x104,... with no gaps or duplicates.
//  3. 3-cycle memory, redirect to 0x2002 with 2 in flight -> both responses dropped, next addr 0x2000,
//     first valid output if_pc_o=0x2000.
//  4. Redirect coincident with mem_resp_valid_i and id_ready_i=0 -> response dropped, FIFO empty next cycle,
//     no request in the redirect cycle.
//  5. mem_req_ready_i=0 for 4 cycles -> addr/valid stable; pc at 0xFFFF_FFFC -> next addr 0x0000_0000.
//  6. rst=0 asynchronously mid-stream with 2 in flight -> outputs 0 immediately; after release, fetch
//     restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and types for the instruction-fetch stage
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_t ZERO_WORD    = '0;
    localparam logic  RST_ENABLE_N = 1'b0;

    // One buffered fetch result as presented to IF/ID
    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped
    function automatic inst_addr_t word_align(input inst_addr_t addr);
        return addr & ~inst_addr_t'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush, used for fetch tags and fetched words
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    // Storage and pointers; storage is cleared on reset so the head reads as zero
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            assert (!(push_i && (count_q == CW'(DEPTH)) && !pop_i));
            assert (!(pop_i && (count_q == '0)));
            if (push_i) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: PC, in-order memory requests, fetch buffer, redirect
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    inst_addr_t    pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    inst_addr_t    tag_head;
    logic          tag_full, tag_empty;
    logic [CW-1:0] tag_count;
    fetch_entry_t  data_head, data_push_entry;
    logic          data_full, data_empty;
    logic [CW-1:0] data_count;

    logic [CW:0]   credits_used;
    logic          req_valid, accept, resp_keep, resp_drop, pop;

    // Request/response/pop decisions; a credit is held from request until the word is popped
    always_comb begin
        credits_used    = {1'b0, outst_q} + {1'b0, data_count};
        req_valid       = rst && !redirect_i && (credits_used < (CW+1)'(FIFO_DEPTH));
        accept          = req_valid && mem_req_ready_i;
        resp_drop       = mem_resp_valid_i && (redirect_i || (discard_q != '0));
        resp_keep       = mem_resp_valid_i && !resp_drop;
        pop             = !data_empty && id_ready_i && !redirect_i;
        data_push_entry = '{pc: tag_head, inst: mem_resp_data_i};
    end

    // Next PC and counters; a redirect marks every request still in flight as wrong-path
    always_comb begin
        pc_d      = pc_q;
        outst_d   = outst_q + CW'(accept) - CW'(mem_resp_valid_i);
        discard_d = discard_q;
        if (redirect_i) begin
            pc_d      = word_align(redirect_pc_i);
            discard_d = outst_d;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_drop) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    // PC and in-flight bookkeeping registers
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            assert (!(mem_resp_valid_i && (outst_q == '0)));
            assert (!(resp_keep && tag_empty));
            assert (!(accept && tag_full));
            assert (!(resp_keep && data_full && !pop));
            assert ((tag_count + discard_q) == outst_q);
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    // Addresses of accepted requests, consumed as their words come back
    fetch_fifo #(
        .WIDTH (INST_ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept),
        .push_data_i (pc_q),
        .pop_i       (resp_keep),
        .flush_i     (redirect_i),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (tag_count)
    );

    // Fetched {pc, inst} pairs waiting for IF/ID
    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_data_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (resp_keep),
        .push_data_i (data_push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_i),
        .head_o      (data_head),
        .full_o      (data_full),
        .empty_o     (data_empty),
        .count_o     (data_count)
    );

    assign mem_req_valid_o = req_valid;
    assign mem_req_addr_o  = rst ? pc_q : ZERO_WORD;
    assign if_valid_o      = !data_empty;
    assign if_pc_o         = data_head.pc;
    assign if_inst_o       = data_head.inst;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch with an in-order memory model
module tb_if_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0100;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    if_fetch #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .id_ready_i       (id_ready_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        inflight[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc, n_acc, n_pop, lat_min, lat_max;
    int          first_acc_cyc, first_val_cyc;
    logic [31:0] exp_req, exp_out;
    logic        s_req_valid, s_if_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic resp_due();
        if (inflight.size() == 0) return 1'b0;
        return (inflight[0].due <= cyc);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, update the reference model
    task automatic cycle(input logic redir, input logic [31:0] tgt, input logic idr, input logic mrdy);
        logic resp_now;
        int   lat;
        redirect_i      = redir;
        redirect_pc_i   = tgt;
        id_ready_i      = idr;
        mem_req_ready_i = mrdy;
        resp_now        = resp_due();
        mem_resp_valid_i = resp_now;
        mem_resp_data_i  = $urandom;
        if (resp_now) mem_resp_data_i = inst_of(inflight[0].addr);
        #1;
        s_req_valid = mem_req_valid_o;
        s_addr      = mem_req_addr_o;
        s_if_valid  = if_valid_o;
        s_pc        = if_pc_o;
        s_inst      = if_inst_o;
        if (redir) chk("no_req_on_redirect", s_req_valid, 1'b0);
        if (s_req_valid) chk("credit_limit", inflight.size() < FIFO_DEPTH, 1'b1);
        if (s_if_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (resp_now) void'(inflight.pop_front());
        if (s_req_valid && mrdy) begin
            chk("req_addr", s_addr, exp_req);
            exp_req += 32'd4;
            acc_log.push_back(s_addr);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            lat = $urandom_range(lat_max, lat_min);
            inflight.push_back('{addr: s_addr, due: cyc + lat});
            n_acc++;
        end
        if (s_if_valid && idr && !redir) begin
            chk("out_pc", s_pc, exp_out);
            chk("out_inst", s_inst, inst_of(exp_out));
            pop_log.push_back(s_pc);
            exp_out += 32'd4;
            n_pop++;
        end
        if (redir) begin
            exp_req = tgt & ~32'h3;
            exp_out = exp_req;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Asserts reset wherever called, checks outputs clear at once, releases at a negedge
    task automatic do_reset();
        rst              = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        id_ready_i       = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        inflight.delete();
        #1;
        chk("rst_req_valid", mem_req_valid_o, 1'b0);
        chk("rst_req_addr", mem_req_addr_o, 32'h0);
        chk("rst_if_valid", if_valid_o, 1'b0);
        chk("rst_if_pc", if_pc_o, 32'h0);
        chk("rst_if_inst", if_inst_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_req = RESET_PC;
        exp_out = RESET_PC;
        first_acc_cyc = -1;
        first_val_cyc = -1;
        cyc = 0;
        n_acc = 0;
        n_pop = 0;
        acc_log.delete();
        pop_log.delete();
    endtask

    initial begin
        int pops_before;
        rst = 1'b1;
        lat_min = 1;
        lat_max = 1;
        #2;

        // Reset and first fetches with single-cycle memory
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t1_first_acc_cycle", first_acc_cyc, 0);
        chk("t1_valid_latency", first_val_cyc - first_acc_cyc, 2);
        chk("t1_acc_count", acc_log.size() >= 3, 1'b1);
        if (acc_log.size() >= 3) begin
            chk("t1_addr0", acc_log[0], 32'h100);
            chk("t1_addr1", acc_log[1], 32'h104);
            chk("t1_addr2", acc_log[2], 32'h108);
        end
        chk("t1_pop_count", pop_log.size() > 0, 1'b1);
        if (pop_log.size() > 0) chk("t1_first_pc", pop_log[0], 32'h100);

        // Downstream stall from reset: credits run out, head held
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_stall_accepts", n_acc, FIFO_DEPTH);
        chk("t2_stall_no_req", s_req_valid, 1'b0);
        chk("t2_stall_valid", s_if_valid, 1'b1);
        chk("t2_stall_head", s_pc, 32'h100);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t2_release_pops", n_pop >= 3, 1'b1);

        // Redirect with two requests in flight on a 3-cycle memory
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 30 && inflight.size() != 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_inflight", inflight.size(), 2);
        cycle(1'b1, 32'h0000_2002, 1'b1, 1'b1);
        acc_log.delete();
        pop_log.delete();
        for (int i = 0; i < 15; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_acc_seen", acc_log.size() > 0, 1'b1);
        if (acc_log.size() > 0) chk("t3_new_addr", acc_log[0], 32'h2000);
        chk("t3_pop_seen", pop_log.size() > 0, 1'b1);
        if (pop_log.size() > 0) chk("t3_new_pc", pop_log[0], 32'h2000);

        // Redirect coinciding with a response while IF/ID stalls
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 30 && !resp_due(); i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t4_resp_due", resp_due(), 1'b1);
        cycle(1'b1, 32'h0000_3000, 1'b0, 1'b1);
        chk("t4_no_req", s_req_valid, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_fifo_empty", s_if_valid, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // Memory back-pressure holds the request; PC wraps at the top of memory
        lat_min = 1;
        lat_max = 1;
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        for (int i = 0; i < 10 && inflight.size() != 0; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            chk("t5_hold_valid", s_req_valid, 1'b1);
            chk("t5_hold_addr", s_addr, 32'hFFFF_FFFC);
        end
        acc_log.delete();
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t5_acc_count", acc_log.size() >= 2, 1'b1);
        if (acc_log.size() >= 2) begin
            chk("t5_top_addr", acc_log[0], 32'hFFFF_FFFC);
            chk("t5_wrap_addr", acc_log[1], 32'h0000_0000);
        end

        // Asynchronous reset mid-stream with two requests in flight
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 30 && inflight.size() != 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t6_inflight", inflight.size(), 2);
        #2;
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t6_restart_seen", acc_log.size() > 0, 1'b1);
        if (acc_log.size() > 0) chk("t6_restart_addr", acc_log[0], RESET_PC);
        chk("t6_pop_seen", pop_log.size() > 0, 1'b1);
        if (pop_log.size() > 0) chk("t6_restart_pc", pop_log[0], RESET_PC);

        // Randomised traffic: stalls, back-pressure, variable latency, redirects
        lat_min = 1;
        lat_max = 4;
        pops_before = n_pop;
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(19, 0) == 0), $urandom,
                  ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
        end
        chk("rand_progress", (n_pop - pops_before) > 50, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
